parity_tx: RTL

- Serial frame transmitter with parity generation.
- Accepts a parallel word over a valid/ready handshake.
- Computes the word's parity as the XOR reduction of all data bits.
- Shifts out one frame, LSB first: start bit, data bits, parity bit, stop bit.
- Sits downstream of the combinational XOR/parity logic and upstream of any serial line or serial checker.

---
 rtl/parity_tx_pkg.sv | 18 +
 rtl/parity_calc.sv | 13 +
 rtl/parity_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity frame transmitter and its
// companion blocks (serial checker, parity helpers).
package parity_tx_pkg;

    // Frame sequencer states; 3-bit encoding keeps the register small and
    // leaves headroom for extra states without changing the port of the type.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Level of the serial line when no frame is in flight (also the stop bit).
    localparam logic TX_IDLE_LVL = 1'b1;

endpackage : parity_tx_pkg

// File: rtl/parity_calc.sv
// Combinational parity of a word: XOR reduction of all bits.
// Kept as its own block so the serial checker can reuse the same logic.
module parity_calc #(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    output logic         parity_o
);

    // Even-parity bit: high when the word holds an odd number of ones.
    assign parity_o = ^data_i;

endmodule : parity_calc

// File: rtl/parity_tx.sv
// Serial frame transmitter: accepts a word over valid/ready and shifts out
// start bit, data bits (LSB first), parity bit and stop bit, each held for
// BIT_CYCLES clocks. All outputs come straight from registers.
// DATA_W must be >= 2 and BIT_CYCLES >= 1.
module parity_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int BIT_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_parity
);

    // Cycle counter needs at least one bit even when BIT_CYCLES == 1.
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic             PAR_SENSE = 1'(ODD_PARITY);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic                par_raw;
    logic                last_cyc;

    parity_calc #(
        .W (DATA_W)
    ) u_parity_calc (
        .data_i   (i_data),
        .parity_o (par_raw)
    );

    // Next-state logic: sequence the frame and precompute registered outputs
    // from the next state so o_tx/o_ready/o_busy line up with the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        last_cyc = (cnt_q == CNT_LAST);

        // Bit-time counter runs in every non-idle state and wraps per bit.
        if (state_q != IDLE) begin
            cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    state_d  = START;
                    shreg_d  = i_data;
                    parity_d = par_raw ^ PAR_SENSE;
                    cnt_d    = '0;
                    bit_d    = '0;
                end
            end
            START: begin
                if (last_cyc) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (last_cyc) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE:    tx_d = TX_IDLE_LVL;
            START:   tx_d = ~TX_IDLE_LVL;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = TX_IDLE_LVL;
            default: tx_d = TX_IDLE_LVL;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State, counters, datapath and output registers; reset aborts any frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= TX_IDLE_LVL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign o_tx     = tx_q;
    assign o_ready  = ready_q;
    assign o_busy   = busy_q;
    assign o_parity = parity_q;

endmodule : parity_tx
